// File: rtl/multi_ref_force_acc.sv
// Multi-channel partial force accumulator: each channel sums FP32 partials per
// reference ID; closed sums leave through one round-robin valid/ready port.

module multi_ref_force_acc_ch #(
    parameter int                DATA_WIDTH   = 32,
    parameter int                ID_W         = 17,
    parameter int                CELL_W       = 9,
    parameter logic [CELL_W-1:0] HOME_CELL_ID = '0,
    parameter bit                SKIP_HOME    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  flush_close,
    input  logic                  grant,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [ID_W-1:0]       in_id,
    input  logic [DATA_WIDTH-1:0] in_fx,
    input  logic [DATA_WIDTH-1:0] in_fy,
    input  logic [DATA_WIDTH-1:0] in_fz,
    output logic                  in_ready,
    output logic                  open,
    output logic                  pending,
    output logic [ID_W-1:0]       pend_id,
    output logic [DATA_WIDTH-1:0] pend_fx,
    output logic [DATA_WIDTH-1:0] pend_fy,
    output logic [DATA_WIDTH-1:0] pend_fz
);
    // Single-cycle FP32 add, round-to-nearest-even, overflow saturates to inf.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [26:0] mx, my, lost;
        logic [27:0] s;
        logic [24:0] m;
        int          ex, ey, sh, e;
        if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
        mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
        my = {y[30:23] != 8'd0, y[22:0], 3'b000};
        sh = ex - ey;
        if (sh > 26) begin
            lost = my;
            my   = '0;
        end else begin
            lost = my & ((27'd1 << sh) - 27'd1);
            my   = my >> sh;
        end
        my[0] = my[0] | (|lost);
        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
        else                s = {1'b0, mx} - {1'b0, my};
        e = ex;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!s[26] && e > 1) begin
                s = s << 1;
                e = e - 1;
            end
        end
        m = {1'b0, s[26:3]};
        if (s[2] && (s[3] || s[1] || s[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (s == 28'd0)    fp_add = 32'd0;
        else if (e >= 255) fp_add = {x[31], 8'hFF, 23'd0};
        else               fp_add = {x[31], m[23] ? 8'(e) : 8'd0, m[22:0]};
    endfunction

    logic                  close_next;
    logic [ID_W-1:0]       cur_id;
    logic [DATA_WIDTH-1:0] acc_x, acc_y, acc_z;
    logic                  accept, same_id, swap, close_cur, drop;

    assign in_ready  = rst & run & ~pending & ~close_next;
    assign accept    = in_valid & in_ready;
    assign same_id   = open & (in_id == cur_id);
    assign swap      = accept & open & ~same_id;
    // Close waits for an empty pending slot (a new-ID beat with last can fill it first).
    assign close_cur = ~pending & open & (close_next | flush_close);
    assign drop      = SKIP_HOME && (cur_id[ID_W-1 -: CELL_W] == HOME_CELL_ID);

    always_ff @(posedge clk) begin
        if (!rst) begin
            open       <= 1'b0;
            close_next <= 1'b0;
            pending    <= 1'b0;
            cur_id     <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            acc_z      <= '0;
            pend_id    <= '0;
            pend_fx    <= '0;
            pend_fy    <= '0;
            pend_fz    <= '0;
        end else begin
            if (grant) pending <= 1'b0;
            if ((swap || close_cur) && !drop) begin
                pending <= 1'b1;
                pend_id <= cur_id;
                pend_fx <= acc_x;
                pend_fy <= acc_y;
                pend_fz <= acc_z;
            end
            if (close_cur) begin
                open       <= 1'b0;
                close_next <= 1'b0;
            end
            if (accept) begin
                open       <= 1'b1;
                close_next <= in_last;
                if (same_id) begin
                    acc_x <= fp_add(acc_x, in_fx);
                    acc_y <= fp_add(acc_y, in_fy);
                    acc_z <= fp_add(acc_z, in_fz);
                end else begin
                    cur_id <= in_id;
                    acc_x  <= in_fx;
                    acc_y  <= in_fy;
                    acc_z  <= in_fz;
                end
            end
        end
    end
endmodule

module multi_ref_force_acc #(
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 8,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int NUM_REF           = 7,
    parameter logic [3*CELL_ID_WIDTH-1:0] HOME_CELL_ID = {3{CELL_ID_WIDTH'(2)}},
    parameter bit SKIP_HOME         = 1'b1,
    localparam int ID_W             = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
    localparam int CH_W             = (NUM_REF > 1) ? $clog2(NUM_REF) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REF-1:0]              in_valid,
    output logic [NUM_REF-1:0]              in_ready,
    input  logic [NUM_REF-1:0]              in_last,
    input  logic [NUM_REF*ID_W-1:0]         in_id,
    input  logic [NUM_REF*DATA_WIDTH-1:0]   in_fx,
    input  logic [NUM_REF*DATA_WIDTH-1:0]   in_fy,
    input  logic [NUM_REF*DATA_WIDTH-1:0]   in_fz,
    input  logic                            in_flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CH_W-1:0]                 out_channel,
    output logic [ID_W-1:0]                 out_id,
    output logic [DATA_WIDTH-1:0]           out_fx,
    output logic [DATA_WIDTH-1:0]           out_fy,
    output logic [DATA_WIDTH-1:0]           out_fz,
    output logic                            flush_done
);
    typedef enum logic [1:0] {RUN, FLUSH_CLOSE, FLUSH_DRAIN, DONE} state_t;

    state_t                             state, state_nx;
    logic                               run, flush_close;
    logic [NUM_REF-1:0]                 open, pending, grant;
    logic [NUM_REF-1:0][ID_W-1:0]       pend_id;
    logic [NUM_REF-1:0][DATA_WIDTH-1:0] pend_fx, pend_fy, pend_fz;
    logic [CH_W-1:0]                    ptr, gnt_idx;
    logic                               gnt_any, load;
    int                                 k;

    for (genvar c = 0; c < NUM_REF; c++) begin : g_ch
        multi_ref_force_acc_ch #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ID_W        (ID_W),
            .CELL_W      (3*CELL_ID_WIDTH),
            .HOME_CELL_ID(HOME_CELL_ID),
            .SKIP_HOME   (SKIP_HOME)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .run        (run),
            .flush_close(flush_close),
            .grant      (grant[c]),
            .in_valid   (in_valid[c]),
            .in_last    (in_last[c]),
            .in_id      (in_id[c*ID_W +: ID_W]),
            .in_fx      (in_fx[c*DATA_WIDTH +: DATA_WIDTH]),
            .in_fy      (in_fy[c*DATA_WIDTH +: DATA_WIDTH]),
            .in_fz      (in_fz[c*DATA_WIDTH +: DATA_WIDTH]),
            .in_ready   (in_ready[c]),
            .open       (open[c]),
            .pending    (pending[c]),
            .pend_id    (pend_id[c]),
            .pend_fx    (pend_fx[c]),
            .pend_fy    (pend_fy[c]),
            .pend_fz    (pend_fz[c])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        run         = 1'b0;
        flush_close = 1'b0;
        flush_done  = 1'b0;
        unique case (state)
            RUN: begin
                run = 1'b1;
                if (in_flush) state_nx = FLUSH_CLOSE;
            end
            FLUSH_CLOSE: begin
                flush_close = 1'b1;
                if (open == '0) state_nx = FLUSH_DRAIN;
            end
            FLUSH_DRAIN: if (pending == '0 && !out_valid) state_nx = DONE;
            DONE: begin
                flush_done = 1'b1;
                state_nx   = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // ptr holds the highest-priority channel for the next grant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        k       = 0;
        for (int i = 0; i < NUM_REF; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REF) k = k - NUM_REF;
            if (!gnt_any && pending[k]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(k);
            end
        end
    end

    assign load = ~out_valid | out_ready;

    always_comb begin
        grant = '0;
        if (load && gnt_any) grant[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_id      <= '0;
            out_fx      <= '0;
            out_fy      <= '0;
            out_fz      <= '0;
            ptr         <= '0;
        end else if (load) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_channel <= gnt_idx;
                out_id      <= pend_id[gnt_idx];
                out_fx      <= pend_fx[gnt_idx];
                out_fy      <= pend_fy[gnt_idx];
                out_fz      <= pend_fz[gnt_idx];
                ptr         <= (gnt_idx == CH_W'(NUM_REF-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multi_ref_force_acc.sv
// Directed bench for multi_ref_force_acc: accumulation, ID change, home drop,
// contention with backpressure, idle flush and mid-stream reset.

module tb_multi_ref_force_acc;
    localparam int NR  = 7;
    localparam int DW  = 32;
    localparam int IDW = 17;

    localparam logic [IDW-1:0] ID_A = {3'd1, 3'd0, 3'd0, 8'd5};
    localparam logic [IDW-1:0] ID_B = {3'd1, 3'd0, 3'd0, 8'd6};
    localparam logic [IDW-1:0] ID_H = {3'd2, 3'd2, 3'd2, 8'd7};

    typedef struct {
        logic [2:0]     ch;
        logic [IDW-1:0] id;
        logic [DW-1:0]  fx, fy, fz;
        int             t;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     in_valid, in_last, in_ready, in_ready2;
    logic [NR*IDW-1:0] in_id;
    logic [NR*DW-1:0]  in_fx, in_fy, in_fz;
    logic              in_flush, out_ready;
    logic              out_valid, flush_done, out_valid2, flush_done2;
    logic [2:0]        out_channel, out_channel2;
    logic [IDW-1:0]    out_id, out_id2;
    logic [DW-1:0]     out_fx, out_fy, out_fz, out_fx2, out_fy2, out_fz2;

    rec_t q[$], q2[$];
    int   cyc = 0, done_cnt = 0, recs_at_done = 0, vld_seen = 0;
    int   n_cmp = 0, n_bad = 0;
    logic [31:0] fval[7] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000};

    multi_ref_force_acc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_id(in_id), .in_fx(in_fx), .in_fy(in_fy), .in_fz(in_fz), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel), .out_id(out_id),
        .out_fx(out_fx), .out_fy(out_fy), .out_fz(out_fz), .flush_done(flush_done)
    );

    multi_ref_force_acc #(.SKIP_HOME(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
        .in_id(in_id), .in_fx(in_fx), .in_fy(in_fy), .in_fz(in_fz), .in_flush(in_flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_channel(out_channel2), .out_id(out_id2),
        .out_fx(out_fx2), .out_fy(out_fy2), .out_fz(out_fz2), .flush_done(flush_done2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready)
            q.push_back('{ch: out_channel, id: out_id, fx: out_fx, fy: out_fy, fz: out_fz, t: cyc});
        if (out_valid2 && out_ready)
            q2.push_back('{ch: out_channel2, id: out_id2, fx: out_fx2, fy: out_fy2, fz: out_fz2, t: cyc});
        if (out_valid) vld_seen <= vld_seen + 1;
        if (flush_done) begin
            done_cnt     <= done_cnt + 1;
            recs_at_done <= q.size();
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // fy/fz carry fixed 0.5 / -1.0 per beat so their sums track beat count.
    task automatic beat(input int c, input logic [IDW-1:0] id, input logic [31:0] fx, input logic last);
        in_valid[c]           = 1'b1;
        in_last[c]            = last;
        in_id[c*IDW +: IDW]   = id;
        in_fx[c*DW +: DW]     = fx;
        in_fy[c*DW +: DW]     = 32'h3F000000;
        in_fz[c*DW +: DW]     = 32'hBF800000;
    endtask

    task automatic idle();
        in_valid = '0;
        in_last  = '0;
    endtask

    function automatic rec_t rec_at(input int i, input bit second);
        rec_t r;
        r = '{ch: '1, id: '1, fx: '1, fy: '1, fz: '1, t: -1};
        if (!second && i < q.size())  r = q[i];
        if (second  && i < q2.size()) r = q2[i];
        return r;
    endfunction

    task automatic wait_valid();
        for (int i = 0; i < 12 && !out_valid; i++) step();
    endtask

    initial begin
        rec_t r;
        int   base, d0, v0, lat;
        logic [2:0] cap_ch;
        logic [31:0] cap_fx;

        rst = 1'b0; in_flush = 1'b0; out_ready = 1'b1;
        in_valid = '0; in_last = '0; in_id = '0; in_fx = '0; in_fy = '0; in_fz = '0;
        steps(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_in_ready_nh", in_ready2, 0);
        chk("rst_flush_done", {flush_done, flush_done2}, 0);
        chk("rst_out_fx", out_fx, 0);
        rst = 1'b1;
        step();
        chk("run_in_ready", in_ready, 7'h7F);

        // single channel, three beats, last on the third
        base = q.size();
        beat(0, ID_A, 32'h3F800000, 1'b0); step();
        beat(0, ID_A, 32'h40000000, 1'b0); step();
        beat(0, ID_A, 32'h40400000, 1'b1); step();
        idle();
        steps(8);
        chk("single_count", q.size() - base, 1);
        r = rec_at(base, 0);
        chk("single_ch", r.ch, 0);
        chk("single_id", r.id, ID_A);
        chk("single_fx", r.fx, 32'h40C00000);
        chk("single_fy", r.fy, 32'h3FC00000);
        chk("single_fz", r.fz, 32'hC0400000);

        // ID change on ch2, then flush closes the B sum
        base = q.size();
        d0   = done_cnt;
        beat(2, ID_A, 32'h3F800000, 1'b0); step();
        beat(2, ID_A, 32'h3F800000, 1'b0); step();
        beat(2, ID_B, 32'h40000000, 1'b0); step();
        idle();
        steps(6);
        chk("idchg_pre_count", q.size() - base, 1);
        r = rec_at(base, 0);
        chk("idchg_a_ch", r.ch, 2);
        chk("idchg_a_id", r.id, ID_A);
        chk("idchg_a_fx", r.fx, 32'h40000000);
        chk("idchg_a_fy", r.fy, 32'h3F800000);
        chk("idchg_a_fz", r.fz, 32'hC0000000);
        chk("idchg_no_done_yet", done_cnt - d0, 0);
        in_flush = 1'b1; step(); in_flush = 1'b0;
        chk("flush_blocks_ready", in_ready, 0);
        for (int i = 0; i < 20 && done_cnt == d0; i++) step();
        steps(3);
        chk("idchg_done_pulses", done_cnt - d0, 1);
        chk("idchg_post_count", q.size() - base, 2);
        chk("idchg_b_before_done", recs_at_done - base, 2);
        r = rec_at(base + 1, 0);
        chk("idchg_b_id", r.id, ID_B);
        chk("idchg_b_fx", r.fx, 32'h40000000);
        chk("idchg_b_fz", r.fz, 32'hBF800000);
        chk("after_flush_ready", in_ready, 7'h7F);

        // home cell: dropped with SKIP_HOME=1, written with SKIP_HOME=0
        base = q.size();
        d0   = q2.size();
        beat(1, ID_H, 32'h3F800000, 1'b1); step();
        idle();
        steps(8);
        chk("home_dropped", q.size() - base, 0);
        chk("home_kept_count", q2.size() - d0, 1);
        r = rec_at(d0, 1);
        chk("home_kept_id", r.id, ID_H);
        chk("home_kept_ch", r.ch, 1);
        chk("home_reopen_ready", in_ready, 7'h7F);

        // contention: all channels close together, output stalled 5 cycles
        rst = 1'b0; step(); rst = 1'b1; step();
        out_ready = 1'b0;
        for (int c = 0; c < NR; c++) beat(c, {3'd3, 3'd1, 3'd1, 8'(c)}, fval[c], 1'b1);
        step();
        idle();
        wait_valid();
        chk("cont_valid", out_valid, 1);
        chk("cont_first_ch", out_channel, 0);
        chk("cont_ready_stall", in_ready, 7'h01);
        cap_ch = out_channel;
        cap_fx = out_fx;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("cont_stall_valid", out_valid, 1);
            chk("cont_stall_ch", out_channel, cap_ch);
            chk("cont_stall_fx", out_fx, cap_fx);
        end
        base = q.size();
        out_ready = 1'b1;
        steps(10);
        chk("cont_count", q.size() - base, 7);
        for (int c = 0; c < NR; c++) begin
            r = rec_at(base + c, 0);
            chk("cont_order_ch", r.ch, c);
            chk("cont_order_fx", r.fx, fval[c]);
            if (c > 0) chk("cont_one_per_cycle", r.t - rec_at(base + c - 1, 0).t, 1);
        end
        chk("cont_ready_after", in_ready, 7'h7F);

        // flush with every channel idle
        base = q.size();
        v0   = vld_seen;
        in_flush = 1'b1; step(); in_flush = 1'b0;
        lat = 1;
        for (int i = 0; i < 10 && !flush_done; i++) begin
            step();
            lat++;
        end
        chk("idle_flush_done", flush_done, 1);
        chk("idle_flush_lat_le3", lat <= 3, 1);
        step();
        chk("idle_flush_one_cycle", flush_done, 0);
        chk("idle_flush_no_valid", vld_seen - v0, 0);
        chk("idle_flush_no_rec", q.size() - base, 0);

        // reset while records are queued and the output is full
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) beat(c, {3'd4, 3'd0, 3'd1, 8'(c)}, fval[c], 1'b1);
        step();
        idle();
        wait_valid();
        steps(1);
        chk("mid_pre_valid", out_valid, 1);
        base = q.size();
        rst = 1'b0;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 0);
        step();
        chk("mid_rst_ready_hold", in_ready, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        steps(10);
        chk("mid_no_stale", q.size() - base, 0);
        chk("mid_ready_back", in_ready, 7'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_ref_force_acc.md
Name: multi_ref_force_acc

Overview:
Parametrised successor to the single-reference partial force accumulator. NUM_REF independent channels each accumulate partial forces for one reference particle. Sums are closed on particle/cell ID change, on an explicit last flag, or on an iteration flush. Closed sums are arbitrated round-robin onto one valid/ready writeback port. Sits between the force evaluation pipelines and the force cache writeback logic.

Parameters:
DATA_WIDTH, 32, IEEE-754 single-precision force word width
PARTICLE_ID_WIDTH, 8, particle index within a cell
CELL_ID_WIDTH, 3, per-axis cell coordinate width; full ID width ID_W = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH, cell ID in the MSBs
NUM_REF, 7, number of accumulation channels
HOME_CELL_ID, {3'd2,3'd2,3'd2}, cell ID whose sums are dropped (never written back)
SKIP_HOME, 1, 1 = drop sums tagged HOME_CELL_ID; 0 = write all

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_valid  in  NUM_REF  per-channel beat valid
in_ready  out  NUM_REF  per-channel beat accept
in_last  in  NUM_REF  beat is the final partial for its ID
in_id  in  NUM_REF*ID_W  full reference ID per channel
in_fx / in_fy / in_fz  in  NUM_REF*DATA_WIDTH  partial forces
in_flush  in  1  close all open sums (end of iteration); single-cycle pulse
out_valid  out  1  writeback record valid
out_ready  in  1  downstream accept
out_channel  out  $clog2(NUM_REF)  source channel
out_id  out  ID_W  reference ID of record
out_fx / out_fy / out_fz  out  DATA_WIDTH  accumulated force
flush_done  out  1  one-cycle pulse: flush finished and all records drained

Behaviour:
- Reset (rst==0 at clk edge): all accumulators 0, open/pending/close_next flags 0, in_ready all 0 during reset, out_valid 0, out_* 0, flush_done 0, arbiter pointer 0, FSM RUN.
- Per channel c:
  - Accumulator is a 1-cycle FP add (FP_ACC): acc <= a + b.
  - Beat accepted when in_valid[c] & in_ready[c].
  - in_ready[c] = ~pending[c] & ~close_next[c] & (FSM==RUN).
- Accepted beat with the channel not open: acc <= partial, cur_id <= in_id, open <= 1.
- Accepted beat with open and in_id == cur_id: acc <= acc + partial.
- Accepted beat with open and in_id != cur_id (any particle or cell bit differs):
  - pending slot <= {cur_id, acc} (the registered sum of all prior beats);
  - acc <= partial, cur_id <= in_id.
- Accepted beat with in_last=1: sum includes that beat. close_next <= 1. The next cycle moves {cur_id, acc} to pending and clears open and close_next.
- Cycles without an accepted beat leave acc unchanged. Invalid beats never contribute. No NaN/denormal special handling beyond FP_ACC.
- Home drop: when SKIP_HOME=1 and the closing ID's cell field == HOME_CELL_ID, the sum is discarded instead of entering pending. The channel still reopens normally.
- Arbiter:
  - Round-robin among pending channels, starting from the channel after the last granted one.
  - When the output register is empty, or (out_valid & out_ready): load the granted record and clear its pending bit in the same cycle.
  - out_* held stable while out_valid & ~out_ready.
  - Throughput: 1 record/cycle.
- FSM:
  - RUN: on in_flush go to FLUSH_CLOSE. in_ready is 0 from the next cycle.
  - FLUSH_CLOSE: each open channel whose pending slot is empty moves its sum to pending (home drop still applies) and clears open. Remain here until no channel is open, then go to FLUSH_DRAIN.
  - FLUSH_DRAIN: wait until no pending bits and out_valid==0 (last record accepted). Then go to DONE.
  - DONE: flush_done=1 for exactly one cycle, then return to RUN.
  - in_flush outside RUN is ignored.
- Simultaneous events:
  - A beat accepted in the same cycle as in_flush is accumulated first; that channel is closed in FLUSH_CLOSE.
  - A channel's pending set and arbiter clear in the same cycle cannot collide: in_ready already blocks a close while pending is set.
- Reset mid-operation discards all sums and pending records with no writeback. out_valid drops in the same cycle that reset is sampled.

Test Plan:
- Single channel:
  - Stimulus: ch0 beats id=A with fx = 1.0 (0x3F800000), 2.0 (0x40000000), 3.0 (0x40400000) back-to-back, last on the third; out_ready=1.
  - Required: one record, out_channel=0, out_id=A, fx=0x40C00000 (6.0).
- ID change:
  - Stimulus: ch2 beats id=A 1.0, 1.0, then id=B 2.0 (no last), then in_flush.
  - Required: record A fx=2.0 (0x40000000) emitted before flush; record B fx=2.0 after flush; flush_done pulses once after the B record is accepted.
- Home drop:
  - Stimulus: ch1 id with cell {2,2,2} and last, SKIP_HOME=1.
  - Required: no record. Repeat with SKIP_HOME=0: record emitted.
- Contention and backpressure:
  - Stimulus: all 7 channels close in the same cycle; out_ready low for 5 cycles, then high.
  - Required: out_* stable while stalled; records emitted in channel order 0..6, one per cycle; in_ready[c] low until channel c's record has been granted.
- Flush with nothing open:
  - Stimulus: in_flush with all channels idle.
  - Required: flush_done pulses within 3 cycles; out_valid never asserts.
- Reset mid-stream:
  - Stimulus: rst=0 while 3 records are pending and out_valid=1.
  - Required: out_valid=0 and in_ready=0 during reset; no stale record appears after rst returns to 1.
